// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and block memory.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.

// state     | meaning
// IDLE      | serving hits, deciding misses
// WRITEBACK | writing dirty victim line to memory
// ALLOCATE  | fetching requested line from memory
// UPDATE    | installing fetched line, then retry as a hit

module data_cache #(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           Read,
    input  logic                           Write,
    input  logic [31:0]                    Address,
    input  logic [31:0]                    Write_data,
    input  logic [2:0]                     Func3,
    output logic [31:0]                    Read_data,
    output logic                           busywait,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [27:0]                    mem_address,
    output logic [WORDS_PER_LINE*32-1:0]   mem_writedata,
    input  logic [WORDS_PER_LINE*32-1:0]   mem_readdata,
    input  logic                           mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]                    hit_count,
    output logic [31:0]                    miss_count
`endif
);

    localparam int LINE_BITS = WORDS_PER_LINE * 32;
    localparam int IDXW      = $clog2(LINES);
    localparam int TAGW      = 28 - IDXW;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

    state_t                 state;
    logic [LINES-1:0]       valid;
    logic [LINES-1:0]       dirty;
    logic [TAGW-1:0]        tags [LINES];
    logic [LINE_BITS-1:0]   data [LINES];
    logic [31:0]            rd_hold;

    logic [IDXW-1:0]        idx;
    logic [TAGW-1:0]        tag;
    logic                   req;
    logic                   hit;
    logic                   load_hit;
    logic                   store_en;
    logic [LINE_BITS-1:0]   cur_line;
    logic [31:0]            cur_word;
    logic [7:0]             cur_byte;
    logic [15:0]            cur_half;
    logic [31:0]            load_val;
    logic [31:0]            wdata_rep;
    logic [3:0]             byte_en;
    logic [31:0]            new_word;
    logic [LINE_BITS-1:0]   store_line;

    assign idx      = Address[4 +: IDXW];
    assign tag      = Address[31 : 4 + IDXW];
    assign req      = Read | Write;
    assign hit      = valid[idx] && (tags[idx] == tag);
    assign load_hit = (state == IDLE) && Read && !Write && hit;
    assign busywait = (state != IDLE) || (req && !hit);

    assign cur_line = data[idx];
    assign cur_word = cur_line[{Address[3:2], 5'b0} +: 32];
    assign cur_byte = cur_word[{Address[1:0], 3'b0} +: 8];
    assign cur_half = cur_word[{Address[1], 4'b0} +: 16];

    always_comb begin
        load_val = cur_word;
        case (Func3)
            3'b000:  load_val = {{24{cur_byte[7]}}, cur_byte};
            3'b001:  load_val = {{16{cur_half[15]}}, cur_half};
            3'b100:  load_val = {24'b0, cur_byte};
            3'b101:  load_val = {16'b0, cur_half};
            default: load_val = cur_word;
        endcase
    end

    assign Read_data = load_hit ? load_val : rd_hold;

    // Replicate store data across lanes, then let the byte enables pick the lanes.
    always_comb begin
        wdata_rep = Write_data;
        byte_en   = 4'b0000;
        case (Func3)
            3'b000: begin
                wdata_rep = {4{Write_data[7:0]}};
                byte_en   = 4'b0001 << Address[1:0];
            end
            3'b001: begin
                wdata_rep = {2{Write_data[15:0]}};
                byte_en   = Address[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                wdata_rep = Write_data;
                byte_en   = 4'b1111;
            end
            default: begin
                wdata_rep = Write_data;
                byte_en   = 4'b0000;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            new_word[i*8 +: 8] = byte_en[i] ? wdata_rep[i*8 +: 8] : cur_word[i*8 +: 8];
        end
        store_line = cur_line;
        store_line[{Address[3:2], 5'b0} +: 32] = new_word;
    end

    assign store_en = (state == IDLE) && Write && hit && (byte_en != 4'b0000);

    always_ff @(posedge Clock) begin
        if (store_en) begin
            data[idx] <= store_line;
        end else if (state == UPDATE) begin
            data[idx] <= mem_readdata;
            tags[idx] <= tag;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            rd_hold       <= 32'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= 28'b0;
            mem_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (store_en)
                                dirty[idx] <= 1'b1;
                            if (load_hit)
                                rd_hold <= load_val;
                        end else if (valid[idx] && dirty[idx]) begin
                            state         <= WRITEBACK;
                            mem_write     <= 1'b1;
                            mem_address   <= {tags[idx], idx};
                            mem_writedata <= cur_line;
                        end else begin
                            state       <= ALLOCATE;
                            mem_read    <= 1'b1;
                            mem_address <= Address[31:4];
                        end
                    end
                end
                WRITEBACK: begin
                    if (!mem_busywait) begin
                        state       <= ALLOCATE;
                        mem_write   <= 1'b0;
                        mem_read    <= 1'b1;
                        mem_address <= Address[31:4];
                    end
                end
                ALLOCATE: begin
                    if (!mem_busywait) begin
                        state    <= UPDATE;
                        mem_read <= 1'b0;
                    end
                end
                UPDATE: begin
                    state      <= IDLE;
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The retry after a refill is the tail of the same miss, not a new hit.
    logic refill;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            hit_count  <= 32'b0;
            miss_count <= 32'b0;
            refill     <= 1'b0;
        end else if (state == IDLE && req) begin
            refill <= 1'b0;
            if (!hit)
                miss_count <= miss_count + 32'd1;
            else if (!refill)
                hit_count <= hit_count + 32'd1;
        end else if (state == UPDATE) begin
            refill <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a block memory that holds each transfer for 4 cycles.
// Counter checks are included when DCACHE_STATS_EN is defined.

module tb_data_cache;

    localparam int MEM_CYCLES = 4;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Read;
    logic         Write;
    logic [31:0]  Address;
    logic [31:0]  Write_data;
    logic [2:0]   Func3;
    logic [31:0]  Read_data;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int tests = 0;
    int fails = 0;

    data_cache dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Read          (Read),
        .Write         (Write),
        .Address       (Address),
        .Write_data    (Write_data),
        .Func3         (Func3),
        .Read_data     (Read_data),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    always #5 Clock = ~Clock;

    // Block memory model: word at byte address a starts as 0x10000000 + a.
    logic [127:0] mem [64];
    logic         mem_init = 1'b0;
    int           mcnt = 0;
    int           wb_count = 0;
    logic [27:0]  wb_addr = '0;
    logic [127:0] wb_data = '0;

    function automatic logic [127:0] blk_init(input int b);
        logic [127:0] v;
        for (int w = 0; w < 4; w++)
            v[w*32 +: 32] = 32'h1000_0000 + 32'(b * 16 + w * 4);
        return v;
    endfunction

    assign mem_busywait = (mem_read || mem_write) && (mcnt != MEM_CYCLES - 1);
    assign mem_readdata = mem[mem_address[5:0]];

    always @(posedge Clock) begin
        if (!mem_init) begin
            for (int b = 0; b < 64; b++)
                mem[b] <= blk_init(b);
            mem_init <= 1'b1;
        end
        if (mem_read || mem_write) begin
            if (mcnt == MEM_CYCLES - 1) begin
                mcnt <= 0;
                if (mem_write) begin
                    mem[mem_address[5:0]] <= mem_writedata;
                    wb_count <= wb_count + 1;
                    wb_addr  <= mem_address;
                    wb_data  <= mem_writedata;
                end
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns stall length and the data seen once the access hits.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] wd, output int busy, output logic [31:0] rdata);
        Read = r; Write = w; Address = a; Func3 = f; Write_data = wd;
        busy = 0;
        @(negedge Clock);
        while (busywait && busy < 50) begin
            busy++;
            @(negedge Clock);
        end
        rdata = Read_data;
        @(posedge Clock);
        #1;
        Read = 1'b0; Write = 1'b0;
    endtask

    int          busy;
    logic [31:0] rd;
`ifdef DCACHE_STATS_EN
    logic [31:0] h0, m0;
`endif

    initial begin
        Reset = 1'b0; Read = 1'b0; Write = 1'b0;
        Address = 32'b0; Write_data = 32'b0; Func3 = 3'b010;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busywait", busywait, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 28'h0);
        check("rst_mem_writedata", mem_writedata, 128'h0);
        check("rst_read_data", Read_data, 32'h0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'h0);
        check("rst_miss_count", miss_count, 32'h0);
`endif
        @(negedge Clock); Reset = 1'b1;
        @(posedge Clock); #1;

        access(1, 0, 32'h04, 3'b010, 0, busy, rd);
        check("lw04_miss_busy", busy, 6);
        check("lw04_miss_data", rd, 32'h1000_0004);
        access(1, 0, 32'h04, 3'b010, 0, busy, rd);
        check("lw04_hit_busy", busy, 0);
        check("lw04_hit_data", rd, 32'h1000_0004);

        access(0, 1, 32'h04, 3'b010, 32'h1234_5678, busy, rd);
        check("sw04_busy", busy, 0);
        access(0, 1, 32'h05, 3'b000, 32'h0000_00AA, busy, rd);
        access(1, 0, 32'h05, 3'b000, 0, busy, rd);
        check("lb05", rd, 32'hFFFF_FFAA);
        access(1, 0, 32'h05, 3'b100, 0, busy, rd);
        check("lbu05", rd, 32'h0000_00AA);
        access(1, 0, 32'h04, 3'b010, 0, busy, rd);
        check("lw04_merged", rd, 32'h1234_AA78);

        access(0, 1, 32'h06, 3'b001, 32'h0000_BBBB, busy, rd);
        access(1, 0, 32'h06, 3'b001, 0, busy, rd);
        check("lh06", rd, 32'hFFFF_BBBB);
        check("lh06_busy", busy, 0);
        access(1, 0, 32'h06, 3'b101, 0, busy, rd);
        check("lhu06", rd, 32'h0000_BBBB);
        check("lhu06_busy", busy, 0);
        access(1, 0, 32'h04, 3'b010, 0, busy, rd);
        check("lw04_after_sh", rd, 32'hBBBB_AA78);

        access(0, 1, 32'h10, 3'b010, 32'hDEAD_BEEF, busy, rd);
        check("sw10_alloc_busy", busy, 6);
        access(1, 0, 32'h90, 3'b010, 0, busy, rd);
        check("lw90_dirty_busy", busy, 10);
        check("lw90_data", rd, 32'h1000_0090);
        check("wb_count", wb_count, 1);
        check("wb_addr", wb_addr, 28'h000_0001);
        check("wb_data", wb_data, {32'h1000_001C, 32'h1000_0018, 32'h1000_0014, 32'hDEAD_BEEF});
        access(1, 0, 32'h10, 3'b010, 0, busy, rd);
        check("lw10_reload_busy", busy, 6);
        check("lw10_reload_data", rd, 32'hDEAD_BEEF);
        check("wb_count_clean", wb_count, 1);

        Read = 1'b1; Write = 1'b0; Address = 32'h20; Func3 = 3'b010;
        @(negedge Clock);
        check("lw20_miss_busy", busywait, 1'b1);
        @(posedge Clock); #1;
        check("alloc_mem_read", mem_read, 1'b1);
        check("alloc_mem_address", mem_address, 28'h000_0002);
        @(posedge Clock); #1;
        Reset = 1'b0; Read = 1'b0;
        #1;
        check("midrst_mem_read", mem_read, 1'b0);
        check("midrst_mem_write", mem_write, 1'b0);
        check("midrst_busywait", busywait, 1'b0);
        @(negedge Clock); Reset = 1'b1;
        @(posedge Clock); #1;
        access(1, 0, 32'h20, 3'b010, 0, busy, rd);
        check("lw20_after_rst_busy", busy, 6);
        check("lw20_after_rst_data", rd, 32'h1000_0020);
        access(1, 0, 32'h04, 3'b010, 0, busy, rd);
        check("lw04_invalidated_busy", busy, 6);
        check("lw04_invalidated_data", rd, 32'h1000_0004);

`ifdef DCACHE_STATS_EN
        h0 = hit_count; m0 = miss_count;
        access(1, 0, 32'h40, 3'b010, 0, busy, rd);
        access(1, 0, 32'h40, 3'b010, 0, busy, rd);
        access(1, 0, 32'h44, 3'b010, 0, busy, rd);
        check("stats_hits", hit_count - h0, 32'd2);
        check("stats_misses", miss_count - m0, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
